core_run_control: RTL and testbench
===================================

# core_run_control

Debug run-control FSM that generates the `core_running`, `core_halted` and `dbg_ret` signals consumed by the pipeline controller. It accepts halt and resume requests from the debug module and `ebreak` events from the pipeline. Before halting, it drains in-flight multicycle work (divider, atomic unit), then captures the halt cause and `dpc`. It also sequences single-step execution. It sits between the debug module / CSR file and the pipeline controller.

## Interface
Parameters:
- `RESET_HALT`, 0: when 1, reset state is HALTED with cause 5 (resethaltreq); when 0, reset state is RUN.
- `DRAIN_TIMEOUT`, 64: maximum number of DRAIN cycles before a forced halt; must be ≥2.

Ports:
- `clk` in 1: core clock.
- `reset_n` in 1: synchronous, active-low reset.
- `haltreq` in 1: level halt request from the debug module.
- `resumereq` in 1: level resume request from the debug module.
- `ebreak` in 1: `ebreak` with dcsr.ebreakm set, committing this cycle.
- `step_en` in 1: dcsr.step.
- `instr_retired` in 1: MEM/WB retired a valid instruction this cycle.
- `drain_busy` in 1: divider or atomic unit has an operation in flight.
- `core_running` out 1: pipeline advance permitted.
- `core_halted` out 1: core halted; pipeline registers held cleared.
- `dbg_ret` out 1: one-cycle pulse; flush IF/ID and redirect PC to `dpc`.
- `halted_ack` out 1: level, equal to `core_halted`.
- `resume_ack` out 1: one-cycle pulse, coincident with `dbg_ret`.
- `dpc_capture` out 1: one-cycle pulse; CSR file latches `dpc` and `dcsr.cause`.
- `dcsr_cause` out 3: halt cause (1 = ebreak, 3 = haltreq, 4 = step, 5 = resethaltreq).
- `step_irq_mask` out 1: masks interrupts while stepping.
- `drain_err` out 1: sticky flag; the last halt was forced by drain timeout.

## Operation
States: RUN, DRAIN, HALTED, RESUME, STEP.

RUN:
- Outputs: `core_running`=1.
- `ebreak` → DRAIN with cause 1.
- Else `haltreq` → DRAIN with cause 3.
- `ebreak` has priority over `haltreq` when both are asserted in the same cycle.

DRAIN:
- Outputs: `core_running`=0, `core_halted`=0.
- The drain counter is cleared on entry and increments each DRAIN cycle.
- `drain_busy`=0 → HALTED.
- Counter reaching `DRAIN_TIMEOUT`-1 while `drain_busy`=1 → HALTED, and `drain_err` is set.
- `dpc_capture` is a Mealy pulse, asserted in the DRAIN cycle that exits.
- `ebreak`, `haltreq` and `resumereq` are ignored.

HALTED:
- Outputs: `core_halted`=1, `halted_ack`=1, `core_running`=0.
- `resumereq`=1 and `haltreq`=0 → RESUME.
- `haltreq`=1 holds the FSM in HALTED regardless of `resumereq`.

RESUME (exactly one cycle):
- Outputs: `dbg_ret`=1, `resume_ack`=1, `core_running`=0, `core_halted`=0.
- `drain_err` is cleared.
- Next state is STEP if `step_en`=1, else RUN.

STEP:
- Outputs: `core_running`=1, `step_irq_mask`=1.
- `ebreak` → DRAIN with cause 1.
- Else `haltreq` → DRAIN with cause 3.
- Else `instr_retired` → DRAIN with cause 4.

`dcsr_cause`:
- Registered; updated only on entry to DRAIN, or at reset when `RESET_HALT`=1.
- Holds its value otherwise. Reset value is 0 when `RESET_HALT`=0.

Other rules:
- All outputs except `dpc_capture` are Moore, decoded from the state register and flags.
- `step_en` is sampled only in RESUME.

## Timing
- Reset values, `RESET_HALT`=0: state RUN, `core_running`=1, all other outputs 0.
- Reset values, `RESET_HALT`=1: state HALTED, `core_halted`=1, `halted_ack`=1, `dcsr_cause`=5, all others 0.
- Halt latency: request sampled at edge N → DRAIN in cycle N+1 → HALTED in cycle N+2 at minimum (with `drain_busy`=0).
- Resume latency: `resumereq` sampled in HALTED at edge N → RESUME in cycle N+1 → RUN/STEP in cycle N+2.
- Step: exactly one retirement is permitted before re-entering DRAIN.
- Reset asserted mid-operation (any state): the reset state is entered at the next edge. Pending counts, `drain_err` and pulses are discarded.
- A `resumereq` held high after RESUME has no effect; resume requires HALTED.

## Structure
- Shared package `core_dbg_pkg` holds:
  - the state enum `run_state_t`;
  - cause constants `CAUSE_EBREAK`=1, `CAUSE_HALTREQ`=3, `CAUSE_STEP`=4, `CAUSE_RESETHALT`=5.
- Sub-module `dbg_drain_timer`:
  - `$clog2(DRAIN_TIMEOUT)`-bit counter with `clear`/`en` inputs and `expired` output;
  - `expired` asserts at count `DRAIN_TIMEOUT`-1.

## Test plan
- Reset with `RESET_HALT`=0, then `haltreq`=1 at cycle 5 with `drain_busy`=0 → DRAIN in cycle 6 with `dpc_capture`=1; HALTED in cycle 7; `dcsr_cause`=3.
- `ebreak` and `haltreq` asserted in the same RUN cycle → `dcsr_cause`=1.
- `drain_busy` high for 10 cycles in DRAIN (`DRAIN_TIMEOUT`=64) → HALTED after the busy drop, `drain_err`=0.
- `drain_busy` held high with `DRAIN_TIMEOUT`=8 → forced HALTED, `drain_err`=1; a subsequent RESUME clears it.
- HALTED, `resumereq`=1 with `step_en`=1 → RESUME pulse (`dbg_ret`=`resume_ack`=1), then STEP with `step_irq_mask`=1. `instr_retired` at cycle 3 of STEP → DRAIN → HALTED with `dcsr_cause`=4.
- HALTED with `haltreq`=`resumereq`=1 → remains HALTED. Reset asserted in STEP with `RESET_HALT`=1 → HALTED with `dcsr_cause`=5 next edge.

Source files
------------

// File: rtl/core_dbg_pkg.sv
// rtl/core_dbg_pkg.sv - shared run-control state and halt-cause definitions
package core_dbg_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED,
        ST_RESUME,
        ST_STEP
    } run_state_t;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_EBREAK    = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ   = 3'd3;
    localparam logic [2:0] CAUSE_STEP      = 3'd4;
    localparam logic [2:0] CAUSE_RESETHALT = 3'd5;

endpackage

// File: rtl/dbg_drain_timer.sv
// rtl/dbg_drain_timer.sv - bounded cycle counter for the pre-halt drain window
module dbg_drain_timer #(
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(DRAIN_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(DRAIN_TIMEOUT - 1);

    logic [W-1:0] count;

    // Stops at LAST so the counter never wraps while the FSM is leaving DRAIN.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/core_run_control.sv
// rtl/core_run_control.sv - debug run-control FSM: halt/drain/resume/single-step sequencing
module core_run_control
    import core_dbg_pkg::*;
#(
    parameter bit RESET_HALT    = 1'b0,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       haltreq,
    input  logic       resumereq,
    input  logic       ebreak,
    input  logic       step_en,
    input  logic       instr_retired,
    input  logic       drain_busy,
    output logic       core_running,
    output logic       core_halted,
    output logic       dbg_ret,
    output logic       halted_ack,
    output logic       resume_ack,
    output logic       dpc_capture,
    output logic [2:0] dcsr_cause,
    output logic       step_irq_mask,
    output logic       drain_err
);

    run_state_t state, next_state;
    logic [2:0] next_cause;
    logic       load_cause;
    logic       set_err;
    logic       clr_err;
    logic       expired;

    dbg_drain_timer #(
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_drain_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state != ST_DRAIN),
        .en     (state == ST_DRAIN),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= RESET_HALT ? ST_HALTED : ST_RUN;
            dcsr_cause <= RESET_HALT ? CAUSE_RESETHALT : CAUSE_NONE;
            drain_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (load_cause) begin
                dcsr_cause <= next_cause;
            end
            if (set_err) begin
                drain_err <= 1'b1;
            end else if (clr_err) begin
                drain_err <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state    = state;
        next_cause    = dcsr_cause;
        load_cause    = 1'b0;
        set_err       = 1'b0;
        clr_err       = 1'b0;
        core_running  = 1'b0;
        core_halted   = 1'b0;
        dbg_ret       = 1'b0;
        dpc_capture   = 1'b0;
        step_irq_mask = 1'b0;

        case (state)
            ST_RUN, ST_STEP: begin
                core_running  = 1'b1;
                step_irq_mask = (state == ST_STEP);
                if (ebreak) begin
                    next_cause = CAUSE_EBREAK;
                    load_cause = 1'b1;
                end else if (haltreq) begin
                    next_cause = CAUSE_HALTREQ;
                    load_cause = 1'b1;
                end else if (state == ST_STEP && instr_retired) begin
                    next_cause = CAUSE_STEP;
                    load_cause = 1'b1;
                end
                if (load_cause) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A timeout while still busy forces the halt and flags it.
                if (!drain_busy || expired) begin
                    next_state  = ST_HALTED;
                    dpc_capture = 1'b1;
                    set_err     = drain_busy;
                end
            end
            ST_HALTED: begin
                core_halted = 1'b1;
                if (resumereq && !haltreq) begin
                    next_state = ST_RESUME;
                    clr_err    = 1'b1;
                end
            end
            ST_RESUME: begin
                dbg_ret    = 1'b1;
                next_state = step_en ? ST_STEP : ST_RUN;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
    end

    assign halted_ack = core_halted;
    assign resume_ack = dbg_ret;

endmodule

// File: tb/tb_core_run_control.sv
// tb/tb_core_run_control.sv - scoreboard bench for core_run_control against a behavioural model
module tb_core_run_control;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;
    localparam int M_RESUME = 3;
    localparam int M_STEP   = 4;
    localparam int NDUT     = 3;

    typedef struct {
        int mode;
        int cnt;
        int cause;
        bit err;
    } mdl_t;

    typedef struct {
        int          idx;
        logic [10:0] exp;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic haltreq = 1'b0, resumereq = 1'b0, ebreak = 1'b0, step_en = 1'b0;
    logic instr_retired = 1'b0, drain_busy = 1'b0;
    logic [10:0] obs [NDUT];

    mdl_t m [NDUT];
    bit   mvalid = 1'b0;
    sb_t  sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic cr, ch, dr, ha, ra, dc, sm, de;
        logic [2:0] cs;
        core_run_control #(
            .RESET_HALT   (g == 2),
            .DRAIN_TIMEOUT(g == 1 ? 8 : 64)
        ) dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .haltreq      (haltreq),
            .resumereq    (resumereq),
            .ebreak       (ebreak),
            .step_en      (step_en),
            .instr_retired(instr_retired),
            .drain_busy   (drain_busy),
            .core_running (cr),
            .core_halted  (ch),
            .dbg_ret      (dr),
            .halted_ack   (ha),
            .resume_ack   (ra),
            .dpc_capture  (dc),
            .dcsr_cause   (cs),
            .step_irq_mask(sm),
            .drain_err    (de)
        );
        assign obs[g] = {cr, ch, dr, ha, ra, dc, cs, sm, de};
    end

    function automatic int timeout_of(int g);
        return (g == 1) ? 8 : 64;
    endfunction

    function automatic logic [10:0] expect_out(mdl_t s, int to, logic busy);
        logic run, hal, ret, cap, msk;
        logic [2:0] c;
        run = 1'b0; hal = 1'b0; ret = 1'b0; cap = 1'b0; msk = 1'b0;
        c = 3'(s.cause);
        case (s.mode)
            M_RUN:    run = 1'b1;
            M_DRAIN:  cap = !busy || (s.cnt == to - 1);
            M_HALTED: hal = 1'b1;
            M_RESUME: ret = 1'b1;
            default:  begin run = 1'b1; msk = 1'b1; end
        endcase
        return {run, hal, ret, hal, ret, cap, c, msk, s.err};
    endfunction

    function automatic mdl_t advance(mdl_t s, int to, bit rh,
                                     logic rn, logic h, logic r, logic e,
                                     logic se, logic ir, logic db);
        mdl_t n;
        int c;
        n = s;
        c = 0;
        if (!rn) begin
            n.mode  = rh ? M_HALTED : M_RUN;
            n.cause = rh ? 5 : 0;
            n.err   = 1'b0;
            n.cnt   = 0;
            return n;
        end
        case (s.mode)
            M_RUN, M_STEP: begin
                if (e) c = 1;
                else if (h) c = 3;
                else if (s.mode == M_STEP && ir) c = 4;
                if (c != 0) begin
                    n.mode = M_DRAIN; n.cause = c; n.cnt = 0;
                end
            end
            M_DRAIN: begin
                if (!db) n.mode = M_HALTED;
                else if (s.cnt == to - 1) begin n.mode = M_HALTED; n.err = 1'b1; end
                else n.cnt = s.cnt + 1;
            end
            M_HALTED: if (r && !h) begin n.mode = M_RESUME; n.err = 1'b0; end
            default:  n.mode = se ? M_STEP : M_RUN;
        endcase
        return n;
    endfunction

    task automatic cyc(input logic rn, input logic h, input logic r, input logic e,
                       input logic se, input logic ir, input logic db);
        @(negedge clk);
        reset_n = rn; haltreq = h; resumereq = r; ebreak = e;
        step_en = se; instr_retired = ir; drain_busy = db;
        if (mvalid) begin
            for (int g = 0; g < NDUT; g++) begin
                sb.push_back('{g, expect_out(m[g], timeout_of(g), db)});
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            m[g] = advance(m[g], timeout_of(g), (g == 2), rn, h, r, e, se, ir, db);
        end
        if (!rn) mvalid = 1'b1;
    endtask

    task automatic idle(input int n, input logic se);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, se, 0, 0);
    endtask

    // Monitor: compares every queued expectation once outputs have settled.
    always @(negedge clk) begin
        sb_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            if (obs[e.idx] !== e.exp) begin
                n_fail++;
                $display("FAIL outputs dut%0d t=%0t got=%b expected=%b", e.idx, $time, obs[e.idx], e.exp);
            end
        end
    end

    initial begin
        int hold;
        logic busy_lvl;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle(4, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        idle(3, 0);
        cyc(1, 1, 0, 1, 0, 0, 0);
        idle(4, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        idle(3, 0);
        cyc(1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 1);
        idle(3, 1);
        cyc(1, 0, 1, 0, 1, 0, 0);
        idle(3, 1);
        cyc(1, 0, 0, 0, 1, 1, 0);
        idle(3, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        idle(1, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(3, 1);

        hold = 0;
        busy_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 80);
                busy_lvl = ($urandom_range(0, 2) != 0);
            end
            hold--;
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                busy_lvl);
        end

        repeat (2) @(negedge clk);
        #4;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
